// File: rtl/uart_rx_wb.sv
// 8N1 UART receiver feeding a small receive FIFO, read out via a Wishbone slave port.
// Latency: byte visible one cycle after the stop-bit sample; Wishbone ack one cycle after request.
// Backpressure: none on the line; a full FIFO drops the byte and sets the sticky overrun flag.
module uart_rx_wb #(
    parameter int CLK_FREQ   = 50_000_000,
    parameter int BAUD       = 115200,
    parameter int FIFO_DEPTH = 16
) (
    input  logic        clk_in,
    input  logic        rst_n,
    input  logic        rx,
    input  logic        wb_cyc_i,
    input  logic        wb_stb_i,
    input  logic        wb_we_i,
    input  logic        wb_adr_i,
    input  logic [15:0] wb_dat_i,
    output logic [15:0] wb_dat_o,
    output logic        wb_ack_o,
    output logic        irq
);

    localparam int DIV   = (CLK_FREQ + BAUD / 2) / BAUD;
    localparam int CNT_W = $clog2(DIV);
    localparam int AW    = $clog2(FIFO_DEPTH);
    localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(DIV / 2 - 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DIV - 1);
    localparam logic [AW:0]      CNT_MAX  = (AW + 1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    logic [1:0]       sync_q, sync_d;
    logic             rxs;
    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       idx_q, idx_d;
    logic [7:0]       shift_q, shift_d;
    logic             tick, rx_push, frame_set;

    logic [7:0]       mem_q [FIFO_DEPTH];
    logic [AW-1:0]    wptr_q, wptr_d, rptr_q, rptr_d;
    logic [AW:0]      count_q, count_d;
    logic             full, not_empty, do_push, pop, ovr_set;
    logic             ovr_q, ovr_d, ferr_q, ferr_d;
    logic             ack_q, ack_d;
    logic [15:0]      dat_q, dat_d;
    logic             req, status_wr;
    logic             unused_wb_bits;

    assign sync_d = {sync_q[0], rx};
    assign rxs    = sync_q[1];
    assign tick   = (cnt_q == '0);

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            sync_q  <= 2'b11;
            state_q <= IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            shift_q <= '0;
        end else begin
            sync_q  <= sync_d;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = tick ? cnt_q : cnt_q - 1'b1;
        idx_d   = idx_q;
        shift_d = shift_q;
        case (state_q)
            IDLE: begin
                cnt_d = cnt_q;
                if (!rxs) begin
                    cnt_d   = CNT_HALF;
                    state_d = START;
                end
            end
            START: if (tick) begin
                if (!rxs) begin
                    cnt_d   = CNT_FULL;
                    idx_d   = '0;
                    state_d = DATA;
                end else begin
                    state_d = IDLE;
                end
            end
            DATA: if (tick) begin
                shift_d = {rxs, shift_q[7:1]};
                cnt_d   = CNT_FULL;
                idx_d   = idx_q + 1'b1;
                if (idx_q == 3'd7) state_d = STOP;
            end
            STOP: if (tick) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        rx_push   = (state_q == STOP) && tick && rxs;
        frame_set = (state_q == STOP) && tick && !rxs;
    end

    // A pop in the push cycle frees the slot, so a full FIFO still accepts the byte.
    assign full      = (count_q == CNT_MAX);
    assign not_empty = (count_q != '0);
    assign req       = wb_cyc_i && wb_stb_i && !ack_q;
    assign status_wr = req && wb_we_i && wb_adr_i;
    assign pop       = req && !wb_we_i && !wb_adr_i && not_empty;
    assign do_push   = rx_push && (!full || pop);
    assign ovr_set   = rx_push && full && !pop;

    always_comb begin
        wptr_d  = wptr_q + AW'(do_push);
        rptr_d  = rptr_q + AW'(pop);
        count_d = count_q + (AW + 1)'(do_push) - (AW + 1)'(pop);
        ovr_d   = ovr_q;
        ferr_d  = ferr_q;
        if (status_wr && wb_dat_i[3]) ovr_d = 1'b0;
        if (status_wr && wb_dat_i[2]) ferr_d = 1'b0;
        if (ovr_set) ovr_d = 1'b1;
        if (frame_set) ferr_d = 1'b1;
        ack_d = req;
        dat_d = 16'h0000;
        if (req && !wb_we_i) begin
            if (wb_adr_i) dat_d = {12'h000, ovr_q, ferr_q, full, not_empty};
            else if (not_empty) dat_d = {8'h00, mem_q[rptr_q]};
        end
    end

    always_ff @(posedge clk_in) begin
        if (do_push) mem_q[wptr_q] <= shift_q;
    end

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
            ovr_q   <= 1'b0;
            ferr_q  <= 1'b0;
            ack_q   <= 1'b0;
            dat_q   <= 16'h0000;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
            ovr_q   <= ovr_d;
            ferr_q  <= ferr_d;
            ack_q   <= ack_d;
            dat_q   <= dat_d;
        end
    end

    assign wb_ack_o       = ack_q;
    assign wb_dat_o       = dat_q;
    assign irq            = not_empty;
    assign unused_wb_bits = ^{wb_dat_i[15:4], wb_dat_i[1:0]};

endmodule

// File: tb/tb_uart_rx_wb.sv
// Scoreboard bench for uart_rx_wb: serial frames and Wishbone accesses drive a queue-based model,
// expected read data is queued at issue and compared by an independent ack monitor.
module tb_uart_rx_wb;

    localparam int CLK_FREQ = 16;
    localparam int BAUD     = 1;
    localparam int DEPTH    = 4;
    localparam int DIV      = (CLK_FREQ + BAUD / 2) / BAUD;

    logic        clk_in = 1'b0;
    logic        rst_n  = 1'b0;
    logic        rx     = 1'b1;
    logic        wb_cyc_i = 1'b0, wb_stb_i = 1'b0, wb_we_i = 1'b0, wb_adr_i = 1'b0;
    logic [15:0] wb_dat_i = 16'h0000;
    logic [15:0] wb_dat_o;
    logic        wb_ack_o;
    logic        irq;

    uart_rx_wb #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD), .FIFO_DEPTH(DEPTH)) dut (
        .clk_in(clk_in), .rst_n(rst_n), .rx(rx),
        .wb_cyc_i(wb_cyc_i), .wb_stb_i(wb_stb_i), .wb_we_i(wb_we_i), .wb_adr_i(wb_adr_i),
        .wb_dat_i(wb_dat_i), .wb_dat_o(wb_dat_o), .wb_ack_o(wb_ack_o), .irq(irq)
    );

    always #5 clk_in = ~clk_in;

    typedef struct {
        bit          chk;
        logic [15:0] val;
        int          tag;
    } exp_t;

    exp_t       exp_q[$];
    logic [7:0] mq[$];
    bit         m_ovr = 0, m_fe = 0;
    int         checks = 0, errors = 0, acks = 0, tag_n = 0;

    function automatic logic [15:0] m_status();
        return {12'h000, m_ovr, m_fe, mq.size() == DEPTH, mq.size() != 0};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    always @(negedge clk_in) begin
        if (rst_n && wb_ack_o) begin
            exp_t e;
            acks++;
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_ack actual=%0h expected=no_ack", wb_dat_o);
            end else begin
                e = exp_q.pop_front();
                if (e.chk) begin
                    checks++;
                    if (wb_dat_o !== e.val) begin
                        errors++;
                        $display("FAIL read#%0d actual=%0h expected=%0h", e.tag, wb_dat_o, e.val);
                    end
                end
            end
        end
    end

    task automatic bus(input logic adr, input logic we, input logic [15:0] dat);
        bit ok = 0;
        @(posedge clk_in); #1;
        wb_cyc_i = 1; wb_stb_i = 1; wb_we_i = we; wb_adr_i = adr; wb_dat_i = dat;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk_in); #1;
            if (wb_ack_o) begin
                ok = 1;
                break;
            end
        end
        wb_cyc_i = 0; wb_stb_i = 0; wb_we_i = 0;
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL ack_timeout actual=none expected=ack");
            void'(exp_q.pop_back());
        end
    endtask

    task automatic wb_rd(input logic adr);
        exp_t e;
        e.chk = 1;
        e.tag = tag_n++;
        if (adr) e.val = m_status();
        else if (mq.size() != 0) e.val = {8'h00, mq.pop_front()};
        else e.val = 16'h0000;
        exp_q.push_back(e);
        bus(adr, 1'b0, 16'h0000);
    endtask

    task automatic wb_wr(input logic adr, input logic [15:0] dat);
        exp_t e;
        e.chk = 0;
        e.val = 16'h0000;
        e.tag = tag_n++;
        if (adr && dat[3]) m_ovr = 0;
        if (adr && dat[2]) m_fe = 0;
        exp_q.push_back(e);
        bus(adr, 1'b1, dat);
    endtask

    task automatic line_bit(input logic v);
        rx = v;
        repeat (DIV) @(posedge clk_in);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b, input bit stop_ok);
        @(posedge clk_in); #1;
        line_bit(1'b0);
        for (int k = 0; k < 8; k++) line_bit(b[k]);
        line_bit(stop_ok);
        line_bit(1'b1);
        if (!stop_ok) m_fe = 1;
        else if (mq.size() == DEPTH) m_ovr = 1;
        else mq.push_back(b);
    endtask

    initial begin
        #900_000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat, a0;
        logic [7:0] b0, b1;

        repeat (3) @(posedge clk_in);
        #1;
        check("rst_ack", wb_ack_o, 0);
        check("rst_dat", wb_dat_o, 0);
        check("rst_irq", irq, 0);
        rst_n = 1;
        repeat (4) @(posedge clk_in);
        wb_rd(1);

        // Single byte with irq latency measured from the falling edge of rx.
        lat = 0;
        fork
            send_byte(8'hA5, 1);
            begin
                @(posedge clk_in);
                for (int i = 0; i < 400; i++) begin
                    @(posedge clk_in);
                    lat++;
                    #1;
                    if (irq) break;
                end
            end
        join
        check("irq_latency", lat, 2 + DIV / 2 + 9 * DIV + 1);
        wb_rd(1);
        wb_rd(0);
        wb_rd(1);
        check("irq_after_pop", irq, 0);

        // Glitch, then frame error and its clear.
        @(posedge clk_in); #1;
        rx = 0;
        repeat (4) @(posedge clk_in);
        #1;
        rx = 1;
        repeat (3 * DIV) @(posedge clk_in);
        wb_rd(1);
        send_byte(8'h3C, 0);
        wb_rd(1);
        check("fe_irq", irq, 0);
        wb_wr(1, 16'h0004);
        wb_rd(1);

        // Overrun with five bytes into a four-deep FIFO.
        for (int i = 1; i <= 5; i++) send_byte(8'(i), 1);
        wb_rd(1);
        for (int i = 0; i < 5; i++) wb_rd(0);
        wb_wr(1, 16'h000C);
        wb_rd(1);

        // Pop whose ack edge coincides with the fifth byte's push.
        for (int i = 1; i <= 4; i++) send_byte(8'(i), 1);
        fork
            send_byte(8'h05, 1);
            begin
                repeat (2 + DIV / 2 + 9 * DIV - 1) @(posedge clk_in);
                wb_rd(0);
            end
        join
        wb_rd(1);
        for (int i = 0; i < 4; i++) wb_rd(0);
        wb_rd(1);

        // Reset in the middle of data bit 3 with a byte already queued.
        send_byte(8'h99, 1);
        @(posedge clk_in); #1;
        rx = 0;
        repeat (DIV + 3 * DIV + DIV / 2) @(posedge clk_in);
        #1;
        rst_n = 0;
        rx = 1;
        mq.delete();
        m_ovr = 0;
        m_fe = 0;
        repeat (2) @(posedge clk_in);
        #1;
        check("midrst_irq", irq, 0);
        check("midrst_ack", wb_ack_o, 0);
        check("midrst_dat", wb_dat_o, 0);
        rst_n = 1;
        repeat (2 * DIV) @(posedge clk_in);
        wb_rd(1);
        send_byte(8'h7E, 1);
        wb_rd(1);
        wb_rd(0);
        wb_rd(1);

        // Held strobe: acks every second cycle.
        b0 = 8'($urandom);
        b1 = 8'($urandom);
        send_byte(b0, 1);
        send_byte(b1, 1);
        a0 = acks;
        for (int i = 0; i < 3; i++) begin
            exp_t e;
            e.chk = 1;
            e.tag = tag_n++;
            e.val = (mq.size() != 0) ? {8'h00, mq.pop_front()} : 16'h0000;
            exp_q.push_back(e);
        end
        @(posedge clk_in); #1;
        wb_cyc_i = 1; wb_stb_i = 1; wb_we_i = 0; wb_adr_i = 0;
        repeat (6) @(posedge clk_in);
        #1;
        wb_cyc_i = 0; wb_stb_i = 0;
        repeat (3) @(posedge clk_in);
        #1;
        check("held_stb_acks", acks - a0, 3);

        // Strobe without cycle must not ack or pop.
        send_byte(8'h42, 1);
        a0 = acks;
        wb_stb_i = 1;
        repeat (3) @(posedge clk_in);
        #1;
        wb_stb_i = 0;
        repeat (2) @(posedge clk_in);
        #1;
        check("no_cyc_acks", acks - a0, 0);
        wb_rd(1);
        wb_rd(0);

        // Randomised mix against the model.
        for (int n = 0; n < 40; n++) begin
            int r = $urandom_range(0, 9);
            if (r <= 3) send_byte(8'($urandom), $urandom_range(0, 7) != 0);
            else if (r <= 6) wb_rd(0);
            else if (r == 7) wb_rd(1);
            else if (r == 8) wb_wr(1, 16'($urandom));
            else wb_wr(0, 16'($urandom));
            check("rand_irq", irq, mq.size() != 0);
        end
        wb_rd(1);

        repeat (5) @(posedge clk_in);
        #1;
        check("scoreboard_drained", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_rx_wb.md
# uart_rx_wb

Byte-oriented UART receiver with a receive FIFO and a Wishbone slave port. Sits between the board `rx` pin and the J1 core's Wishbone bus inside `j1_top`, feeding serial input to the Forth console. It deserialises 8N1 frames, buffers them, and exposes data and status registers to the CPU.

## Interface

**Parameters**
- `CLK_FREQ`, default 50_000_000: clock frequency in Hz.
- `BAUD`, default 115200: line rate. `DIV = (CLK_FREQ + BAUD/2) / BAUD`, must be ≥ 4.
- `FIFO_DEPTH`, default 16: receive FIFO entries. Must be a power of 2.

**Ports**
- `clk_in`, input, 1: system clock; all logic is on the rising edge.
- `rst_n`, input, 1: asynchronous, active-low reset.
- `rx`, input, 1: serial line, asynchronous, idle high.
- `wb_cyc_i`, input, 1: Wishbone cycle.
- `wb_stb_i`, input, 1: Wishbone strobe.
- `wb_we_i`, input, 1: Wishbone write enable.
- `wb_adr_i`, input, 1: register select. 0 = DATA, 1 = STATUS.
- `wb_dat_i`, input, 16: write data.
- `wb_dat_o`, output, 16: read data.
- `wb_ack_o`, output, 1: Wishbone acknowledge.
- `irq`, output, 1: high while the FIFO is non-empty.

## Operation

**Input synchroniser**
- Two flops on `rx`, both reset to 1.
- Only the synchronised value `rxs` is used.

**Receiver FSM**
- States: IDLE, START, DATA, STOP.
- Bit-timer `cnt`, width ceil(log2(DIV)). Bit index `idx`, 3 bits.
- IDLE:
  - On `rxs` = 0, load `cnt` = DIV/2 − 1 and go to START.
- START:
  - When `cnt` = 0, sample `rxs`.
  - If it is 0, load `cnt` = DIV − 1 and `idx` = 0, and go to DATA.
  - If it is 1 (glitch), return to IDLE with no flag set.
- DATA:
  - At each `cnt` = 0, shift `rxs` into the shift register LSB-first and reload DIV − 1.
  - After `idx` = 7 is sampled, go to STOP.
- STOP:
  - At `cnt` = 0, sample `rxs`.
  - If 1, push the byte.
  - If 0, set sticky `frame_err` and discard the byte.
  - Go to IDLE in both cases. A new start bit is detectable on the next cycle.

**FIFO**
- Circular buffer with read/write pointers and a count.
- A push when full (and no same-cycle pop) drops the byte and sets sticky `overrun`.
- Push and pop in the same cycle:
  - Both take effect; count is unchanged.
  - This also applies when full: the pop frees the slot.

**Registers**
- DATA read:
  - `wb_dat_o` = {8'h00, head byte} and pop one entry.
  - When empty, returns 16'h0000 and does not pop.
  - DATA write is acknowledged and ignored.
- STATUS read: `wb_dat_o` = {12'h000, overrun, frame_err, full, not_empty}.
- STATUS write:
  - Writing 1 to bit 3 clears `overrun`; writing 1 to bit 2 clears `frame_err`.
  - Other bits are ignored.
  - If a clear coincides with a new error event in the same cycle, the set wins.

**Reset**
- `wb_ack_o` = 0, `wb_dat_o` = 0, `irq` = 0.
- FIFO empty, pointers 0, flags 0, FSM in IDLE.
- Reset asserted mid-frame abandons the frame. No partial byte is ever pushed.

## Timing

**Wishbone**
- `wb_ack_o` rises one cycle after `wb_cyc_i & wb_stb_i` are sampled high with `wb_ack_o` low.
- It stays high for exactly one cycle, so back-to-back strobes are acked every second cycle.
- `wb_dat_o` is registered and valid in the ack cycle.
- The pop or flag clear takes effect in the ack cycle, and is performed exactly once per ack.
- If `wb_cyc_i` drops before ack, no ack and no side effect.

**Receive latency**
- Sampling instants, counted from the first clock where `rxs` = 0:
  - start check at DIV/2;
  - data bit k at DIV/2 + (k+1)·DIV;
  - stop bit at DIV/2 + 9·DIV.
- The byte is visible (`not_empty`, `irq`) on the following cycle.
- `rxs` lags `rx` by 2 cycles.

**Other**
- `irq` and status bits are registered from FIFO state, with no combinational path from Wishbone inputs.

## Test plan

All scenarios use `CLK_FREQ` = 16, `BAUD` = 1 (DIV = 16), `FIFO_DEPTH` = 4.

1. **Single byte.** Send 8'hA5 in 8N1.
   - `irq` rises at cycle 2 + 8 + 144 + 1 after `rx` falls.
   - STATUS read = 16'h0001; DATA read = 16'h00A5.
   - Then STATUS = 16'h0000 and `irq` = 0.
2. **Glitch and frame error.**
   - A 4-cycle low pulse on `rx` → FSM returns to IDLE, STATUS stays 0.
   - A frame 8'h3C with stop bit 0 → STATUS = 16'h0004 and FIFO empty.
   - Write 16'h0004 to STATUS → STATUS = 0.
3. **Overrun.** Send 5 bytes 8'h01–8'h05 with no reads.
   - STATUS = 16'h000B.
   - DATA reads return 01, 02, 03, 04, then 16'h0000.
4. **Pop and push in the same cycle.** Fill the FIFO to 4, then time a DATA read so its ack cycle coincides with the 5th byte's push.
   - No overrun; count stays 4.
   - Order is 02, 03, 04, 05.
5. **Reset mid-frame.** Pulse `rst_n` low during data bit 3 of a frame, then send 8'h7E.
   - After reset all outputs are 0.
   - Only 8'h7E is read back, with no error flags.
6. **Wishbone protocol.**
   - Hold stb/cyc high for 6 cycles on DATA with 2 bytes queued → exactly 3 acks, returning byte0, byte1, 0.
   - Drop cyc before ack → no pop.
